// File: rtl/traffic_pkg.sv
// Shared types, default phase lengths and small helpers for the traffic-light
// and pedestrian-crossing stages.
package traffic_pkg;

   // Vehicle lamp state as presented by the upstream traffic-light stage.
   typedef enum logic [1:0] {
      LAMP_RED    = 2'd0,
      LAMP_GREEN  = 2'd1,
      LAMP_YELLOW = 2'd2
   } lamp_t;

   // Pedestrian crossing phases.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      FLASH = 2'd2
   } ped_state_t;

   localparam int DEF_WALK_CYCLES     = 3;
   localparam int DEF_FLASH_CYCLES    = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

   // Larger of two integers, used to size the shared phase timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // True when exactly one of the three vehicle lamps is lit.
   function automatic logic lamps_onehot(input logic r, input logic g, input logic y);
      logic [1:0] sum;
      sum = {1'b0, r} + {1'b0, g} + {1'b0, y};
      return (sum == 2'd1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, saturating debounce counter
// and a single press pulse per accepted press.
module btn_debounce
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_async,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // Next-state: synchronize, count consecutive highs, pulse on the final count.
   always_comb begin
      sync1_d = btn_async;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync2_q) begin
         // Counter saturates so a held button produces only one pulse.
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         press_d = (cnt_q == CNT_LAST);
      end else begin
         cnt_d   = {CW{1'b0}};
         press_d = 1'b0;
      end
   end

   // Synchronizer, counter and pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants a timed WALK / flashing phase inside
// a vehicle RED phase when a debounced request is pending and lamps are sane.
module ped_crossing_ctrl
   import traffic_pkg::*;
#(
   parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
   parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic red,
   input  logic green,
   input  logic yellow,
   input  logic ped_btn,
   output logic walk,
   output logic dont_walk,
   output logic req_pending,
   output logic served,
   output logic fault
);

   localparam int            TW         = $clog2(max_int(WALK_CYCLES, FLASH_CYCLES) + 1);
   localparam logic [TW-1:0] WALK_LOAD  = TW'(WALK_CYCLES - 1);
   localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_CYCLES - 1);

   ped_state_t    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          red_q, red_d;
   logic          walk_q, walk_d;
   logic          dont_walk_q, dont_walk_d;
   logic          req_q, req_d;
   logic          served_q, served_d;
   logic          fault_q, fault_d;
   logic          press_s;
   logic          red_rise_s;
   logic          grant_s;
   logic          abort_s;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_async (ped_btn),
      .press     (press_s)
   );

   // Phase sequencing, timer, request latch, fault latch and lamp decode.
   always_comb begin
      red_d      = red;
      red_rise_s = red & ~red_q;
      // Grant looks only at the registered request, so a press landing on
      // the red rise waits for the next RED phase.
      grant_s    = (state_q == IDLE) & red_rise_s & req_q & ~fault_q;
      abort_s    = (state_q != IDLE) & (~red | fault_q);
      state_d    = state_q;
      timer_d    = timer_q;
      served_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_s) begin
               state_d = WALK;
               timer_d = WALK_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         WALK: begin
            if (abort_s) begin
               state_d  = IDLE;
               timer_d  = {TW{1'b0}};
               served_d = 1'b1;
            end else if (timer_q == {TW{1'b0}}) begin
               state_d = FLASH;
               timer_d = FLASH_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         FLASH: begin
            if (abort_s) begin
               state_d  = IDLE;
               timer_d  = {TW{1'b0}};
               served_d = 1'b1;
            end else if (timer_q == {TW{1'b0}}) begin
               state_d  = IDLE;
               served_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
         end
      endcase

      // Clear on grant beats a simultaneous press; presses during WALK drop.
      if (grant_s) begin
         req_d = 1'b0;
      end else if (press_s && ((state_q == IDLE) || (state_q == FLASH))) begin
         req_d = 1'b1;
      end else begin
         req_d = req_q;
      end

      fault_d = fault_q | ~lamps_onehot(red, green, yellow);

      walk_d = (state_d == WALK);
      case (state_d)
         IDLE:    dont_walk_d = 1'b1;
         WALK:    dont_walk_d = 1'b0;
         // First FLASH cycle shows 1, then the lamp toggles every cycle.
         FLASH:   dont_walk_d = (state_q == FLASH) ? ~dont_walk_q : 1'b1;
         default: dont_walk_d = 1'b1;
      endcase
   end

   // State, timer and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         timer_q     <= {TW{1'b0}};
         red_q       <= 1'b0;
         walk_q      <= 1'b0;
         dont_walk_q <= 1'b1;
         req_q       <= 1'b0;
         served_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         red_q       <= red_d;
         walk_q      <= walk_d;
         dont_walk_q <= dont_walk_d;
         req_q       <= req_d;
         served_q    <= served_d;
         fault_q     <= fault_d;
      end
   end

   assign walk        = walk_q;
   assign dont_walk   = dont_walk_q;
   assign req_pending = req_q;
   assign served      = served_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed, scoreboard-based bench for ped_crossing_ctrl with default parameters.
// Expected output vector order: {walk, dont_walk, req_pending, served, fault}.
module tb_ped_crossing_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   logic red, green, yellow, ped_btn;
   logic walk, dont_walk, req_pending, served, fault;

   typedef struct {
      logic [4:0] exp;
      string      tag;
   } sb_t;

   sb_t sb_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   ped_crossing_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .red         (red),
      .green       (green),
      .yellow      (yellow),
      .ped_btn     (ped_btn),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .req_pending (req_pending),
      .served      (served),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   // Pop the oldest expectation and compare it with the current outputs.
   task automatic check_out();
      sb_t        e;
      logic [4:0] obs;
      e   = sb_q.pop_front();
      obs = {walk, dont_walk, req_pending, served, fault};
      n_cmp++;
      assert (obs === e.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
   endtask

   // Queue an expectation for the next edge, advance one clock and compare.
   task automatic tick(input logic [4:0] exp, input string tag);
      sb_t e;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Queue an expectation and compare without waiting for a clock edge.
   task automatic check_now(input logic [4:0] exp, input string tag);
      sb_t e;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
      #1;
      check_out();
   endtask

   task automatic lamps(input logic r, input logic g, input logic y);
      red    = r;
      green  = g;
      yellow = y;
   endtask

   // Hold the button until the request latches (6 edges to press, 7th latches).
   task automatic press_req(input logic [4:0] base, input string tag);
      ped_btn = 1'b1;
      for (int i = 0; i < 6; i++) tick(base, tag);
      tick(base | 5'b00100, tag);
      ped_btn = 1'b0;
   endtask

   // Six-cycle RED with a pending request: full crossing, then back to GREEN.
   task automatic red_crossing(input string tag);
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b10000, {tag, "_walk0"});
      tick(5'b10000, {tag, "_walk1"});
      tick(5'b10000, {tag, "_walk2"});
      tick(5'b01000, {tag, "_flash_on"});
      tick(5'b00000, {tag, "_flash_off"});
      tick(5'b01010, {tag, "_served"});
      lamps(1'b0, 1'b1, 1'b0);
      tick(5'b01000, {tag, "_idle"});
   endtask

   // Six-cycle RED in which no WALK may be granted.
   task automatic red_no_grant(input logic [4:0] exp, input string tag);
      lamps(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) tick(exp, tag);
      lamps(1'b0, 1'b1, 1'b0);
      tick(exp, tag);
   endtask

   initial begin
      logic [6:0] bounce;

      // Reset held with button pressed and RED lit.
      reset_n = 1'b0;
      ped_btn = 1'b1;
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b01000, "reset_hold0");
      tick(5'b01000, "reset_hold1");
      tick(5'b01000, "reset_hold2");
      ped_btn = 1'b0;
      lamps(1'b0, 1'b1, 1'b0);
      reset_n = 1'b1;
      tick(5'b01000, "reset_release");

      // Normal crossing.
      press_req(5'b01000, "normal_press");
      tick(5'b01100, "normal_wait0");
      tick(5'b01100, "normal_wait1");
      red_crossing("normal");

      // Bounce rejection: never four consecutive highs.
      bounce = 7'b0111011;
      for (int i = 6; i >= 0; i--) begin
         ped_btn = bounce[i];
         tick(5'b01000, "bounce_btn");
      end
      ped_btn = 1'b0;
      tick(5'b01000, "bounce_settle0");
      tick(5'b01000, "bounce_settle1");
      red_no_grant(5'b01000, "bounce_red");

      // Abort: red falls during WALK.
      press_req(5'b01000, "abort_press");
      tick(5'b01100, "abort_wait0");
      tick(5'b01100, "abort_wait1");
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b10000, "abort_walk0");
      tick(5'b10000, "abort_walk1");
      lamps(1'b0, 1'b1, 1'b0);
      tick(5'b01010, "abort_served");
      tick(5'b01000, "abort_no_flash0");
      tick(5'b01000, "abort_no_flash1");
      tick(5'b01000, "abort_no_flash2");

      // Press accepted on the red_rise edge waits for the next RED.
      ped_btn = 1'b1;
      for (int i = 0; i < 6; i++) tick(5'b01000, "rise_press");
      ped_btn = 1'b0;
      red_no_grant(5'b01100, "rise_no_grant");
      tick(5'b01100, "rise_green");
      red_crossing("rise_next_red");

      // Press during WALK is ignored.
      press_req(5'b01000, "wpress_first");
      tick(5'b01100, "wpress_gap0");
      tick(5'b01100, "wpress_gap1");
      tick(5'b01100, "wpress_gap2");
      ped_btn = 1'b1;
      for (int i = 0; i < 4; i++) tick(5'b01100, "wpress_hold");
      red_crossing("wpress");
      ped_btn = 1'b0;
      tick(5'b01000, "wpress_dropped0");
      tick(5'b01000, "wpress_dropped1");

      // Reset in the middle of a crossing loses the request.
      press_req(5'b01000, "midrst_press");
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b10000, "midrst_walk0");
      tick(5'b10000, "midrst_walk1");
      reset_n = 1'b0;
      check_now(5'b01000, "midrst_async");
      lamps(1'b0, 1'b1, 1'b0);
      tick(5'b01000, "midrst_hold");
      reset_n = 1'b1;
      tick(5'b01000, "midrst_release");
      red_no_grant(5'b01000, "midrst_lost_req");

      // Fault: two lamps lit for one cycle aborts and blocks grants.
      press_req(5'b01000, "fault_press");
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b10000, "fault_walk");
      lamps(1'b1, 1'b1, 1'b0);
      tick(5'b10001, "fault_set");
      lamps(1'b1, 1'b0, 1'b0);
      tick(5'b01011, "fault_abort");
      tick(5'b01001, "fault_sticky");
      lamps(1'b0, 1'b1, 1'b0);
      tick(5'b01001, "fault_green");
      press_req(5'b01001, "fault_req_latch");
      red_no_grant(5'b01101, "fault_no_grant");
      reset_n = 1'b0;
      check_now(5'b01000, "fault_reset");
      tick(5'b01000, "fault_reset_hold");
      reset_n = 1'b1;
      tick(5'b01000, "fault_reset_release");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
